// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes and FSM state type shared by the Morse playback logic.
package morse_pkg;
  localparam logic [1:0] SYM_NOP  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_GAP  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE} state_t;
endpackage

// File: rtl/unit_tick_gen.sv
// unit_tick_gen: prescaler counting 0..TICK_DIV-1 with a one-cycle tick on wrap and a synchronous clear.
module unit_tick_gen #(
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/morse_playback.sv
// morse_playback: plays one 2-bit Morse symbol at a time as a timed tone_out waveform.
// Optional symbol counter output sym_count is enabled by defining MORSE_PLAYBACK_CNT_EN.
module morse_playback #(
  parameter int TICK_DIV   = 12500000,
  parameter int DOT_UNITS  = 1,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       tone_out,
  output logic       busy,
  output logic       done
`ifdef MORSE_PLAYBACK_CNT_EN
  ,
  output logic [7:0] sym_count
`endif
);
  import morse_pkg::*;
  localparam int MAX_DG = DASH_UNITS > GAP_UNITS ? DASH_UNITS : GAP_UNITS;
  localparam int MAX_U  = DOT_UNITS > MAX_DG ? DOT_UNITS : MAX_DG;
  localparam int UW     = $clog2(MAX_U) > 0 ? $clog2(MAX_U) : 1;
  state_t state, state_nx;
  logic [1:0] sym;
  logic [UW-1:0] unit_cnt, unit_end;
  logic tick, accept, last_unit;
  assign sym_ready = state == ST_IDLE;
  assign busy      = state != ST_IDLE;
  assign accept    = sym_valid && sym_ready;
  unit_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );
  always_comb begin
    unit_end  = state == ST_MARK ? (sym == SYM_DASH ? UW'(DASH_UNITS - 1) : UW'(DOT_UNITS - 1))
                                 : (sym == SYM_GAP ? UW'(GAP_UNITS - 1) : '0);
    last_unit = tick && unit_cnt == unit_end;
    state_nx  = state;
    case (state)
      ST_IDLE:  state_nx = !accept ? ST_IDLE :
                           (sym_in == SYM_DOT || sym_in == SYM_DASH) ? ST_MARK :
                           sym_in == SYM_GAP ? ST_SPACE : ST_IDLE;
      ST_MARK:  state_nx = last_unit ? ST_SPACE : ST_MARK;
      ST_SPACE: state_nx = last_unit ? ST_IDLE : ST_SPACE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= ST_IDLE;
      sym      <= SYM_NOP;
      unit_cnt <= '0;
      tone_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      tone_out <= state_nx == ST_MARK;
      done     <= (accept && sym_in == SYM_NOP) || (state == ST_SPACE && state_nx == ST_IDLE);
      if (accept) sym <= sym_in;
      unit_cnt <= (accept || state_nx != state) ? '0 : unit_cnt + UW'(tick);
    end
`ifdef MORSE_PLAYBACK_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) sym_count <= '0;
    else if (done && sym_count != 8'hff) sym_count <= sym_count + 8'd1;
`endif
endmodule

// File: tb/tb_morse_playback.sv
// tb_morse_playback: scoreboard bench for morse_playback with a small timing scale.
module tb_morse_playback;
  import morse_pkg::*;
  localparam int TD = 4, DU = 1, DA = 3, GU = 3;
  localparam logic [3:0] E_MARK = 4'b1100, E_SPACE = 4'b0100, E_DONE = 4'b0011, E_IDLE = 4'b0010;
  logic clk = 0, rst = 0, sym_valid = 0;
  logic [1:0] sym_in = SYM_NOP;
  logic sym_ready, tone_out, busy, done;
`ifdef MORSE_PLAYBACK_CNT_EN
  logic [7:0] sym_count;
`endif
  int n_cmp = 0, n_err = 0;
  logic [3:0] q[$];
  logic [3:0] e, got;
  always #5 clk = ~clk;
  morse_playback #(.TICK_DIV(TD), .DOT_UNITS(DU), .DASH_UNITS(DA), .GAP_UNITS(GU)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .tone_out  (tone_out),
    .busy      (busy),
    .done      (done)
`ifdef MORSE_PLAYBACK_CNT_EN
    ,
    .sym_count (sym_count)
`endif
  );
  // Expected {tone,busy,ready,done} per cycle, starting with the cycle after accept.
  function automatic void push_sym(input logic [1:0] s);
    int m  = s == SYM_DOT ? DU : s == SYM_DASH ? DA : 0;
    int sp = s == SYM_GAP ? GU : s == SYM_NOP ? 0 : 1;
    for (int i = 0; i < m * TD; i++) q.push_back(E_MARK);
    for (int i = 0; i < sp * TD; i++) q.push_back(E_SPACE);
    q.push_back(E_DONE);
  endfunction
  task automatic test_reset();
    repeat (3) q.push_back(E_IDLE);
    for (int c = 1; q.size() > 0; c++) begin
      @(negedge clk);
      e = q.pop_front(); got = {tone_out, busy, sym_ready, done}; n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL reset cyc %0d: got tbrd=%b want %b", c, got, e); end
      @(posedge clk); #1;
      if (c == 2) rst = 1;
    end
  endtask
  task automatic test_single(input logic [1:0] s, input string nm);
    sym_in = s; sym_valid = 1;
    @(posedge clk); #1;
    sym_valid = 0;
    push_sym(s); q.push_back(E_IDLE);
    for (int c = 1; q.size() > 0; c++) begin
      @(negedge clk);
      e = q.pop_front(); got = {tone_out, busy, sym_ready, done}; n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL %s cyc %0d: got tbrd=%b want %b", nm, c, got, e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_gap_nop();
    sym_in = SYM_GAP; sym_valid = 1;
    @(posedge clk); #1;
    sym_valid = 0;
    push_sym(SYM_GAP); push_sym(SYM_NOP); q.push_back(E_IDLE);
    for (int c = 1; q.size() > 0; c++) begin
      @(negedge clk);
      e = q.pop_front(); got = {tone_out, busy, sym_ready, done}; n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL gap_nop cyc %0d: got tbrd=%b want %b", c, got, e); end
      @(posedge clk); #1;
      if (c == 12) begin sym_in = SYM_NOP; sym_valid = 1; end
      if (c == 13) sym_valid = 0;
    end
  endtask
  task automatic test_back_to_back();
    sym_in = SYM_DOT; sym_valid = 1;
    @(posedge clk); #1;
    sym_in = SYM_DASH;
    push_sym(SYM_DOT); push_sym(SYM_DASH); q.push_back(E_IDLE);
    for (int c = 1; q.size() > 0; c++) begin
      @(negedge clk);
      e = q.pop_front(); got = {tone_out, busy, sym_ready, done}; n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL b2b cyc %0d: got tbrd=%b want %b", c, got, e); end
      @(posedge clk); #1;
      if (c == 9) sym_valid = 0;
    end
  endtask
  task automatic test_mid_reset();
    sym_in = SYM_DASH; sym_valid = 1;
    @(posedge clk); #1;
    sym_valid = 0;
    repeat (5) q.push_back(E_MARK);
    repeat (4) q.push_back(E_IDLE);
    for (int c = 1; q.size() > 0; c++) begin
      @(negedge clk);
      e = q.pop_front(); got = {tone_out, busy, sym_ready, done}; n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL mid_reset cyc %0d: got tbrd=%b want %b", c, got, e); end
      @(posedge clk); #1;
      if (c == 5) rst = 0;
      if (c == 7) rst = 1;
    end
  endtask
`ifdef MORSE_PLAYBACK_CNT_EN
  task automatic test_count();
    rst = 0; #1;
    n_cmp++;
    if (sym_count !== 8'd0) begin n_err++; $display("FAIL cnt_reset: got %0d want 0", sym_count); end
    @(posedge clk); #1; rst = 1;
    sym_in = SYM_NOP; sym_valid = 1;
    repeat (3) begin @(posedge clk); #1; end
    sym_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (sym_count !== 8'd3) begin n_err++; $display("FAIL cnt_three: got %0d want 3", sym_count); end
    sym_valid = 1;
    repeat (300) begin @(posedge clk); #1; end
    sym_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (sym_count !== 8'd255) begin n_err++; $display("FAIL cnt_sat: got %0d want 255", sym_count); end
  endtask
`endif
  initial begin
    test_reset();
    test_single(SYM_DOT, "dot");
    test_single(SYM_DASH, "dash");
    test_gap_nop();
    test_back_to_back();
    test_mid_reset();
    test_single(SYM_DOT, "dot_after_reset");
`ifdef MORSE_PLAYBACK_CNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
